uart_rx_oversampler: RTL and testbench
======================================

Name: uart_rx_oversampler

Overview:
- 8N1 UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly downstream of baud_rate_generator and consumes its `tick` output, which pulses at BAUD_RATE*SAMPLE_RATE.
- Synchronises the asynchronous `rx` line, validates the start bit, mid-bit samples the data and stop bits, then presents each received byte on a valid/ready interface.
- Flags framing errors and overruns.

Parameters:
- SAMPLE_RATE, 16, ticks per bit period; even, >=4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle oversample strobe from baud_rate_generator
- rx  input  1  asynchronous serial line; idle high
- data  output  DATA_BITS  received byte, LSB = first bit on the line
- data_valid  output  1  data holds an unconsumed byte
- data_ready  input  1  consumer accepts data when high with data_valid
- framing_error  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full

Behaviour:
- Reset:
  - Asynchronous, active-low; all flops clear immediately on reset_n low.
  - State = IDLE; sync flops = 1; tick counter = 0; bit counter = 0; shift register = 0.
  - data = 0, data_valid = 0, framing_error = 0, overrun = 0.
- Synchroniser:
  - rx passes through 2 flops before any use. `rx_s` denotes the second flop's output.
- Counters:
  - Tick counter is $clog2(SAMPLE_RATE) bits and advances only on cycles with tick = 1.
  - "Sample point" means the tick on which the counter reaches its target; the counter clears on that same tick.
- State IDLE:
  - rx_s == 0 on any clock cycle -> enter START, clear tick counter.
- State START:
  - At the tick counter's SAMPLE_RATE/2 tick (mid start bit):
    - rx_s == 0 -> enter DATA, clear the bit counter.
    - rx_s == 1 -> glitch; return to IDLE. No output activity.
- State DATA:
  - Every SAMPLE_RATE ticks, shift rx_s into the shift register MSB and shift right, giving LSB-first assembly.
  - After DATA_BITS samples -> enter STOP.
- State STOP:
  - Sample after SAMPLE_RATE ticks.
  - rx_s == 1 -> byte complete; deliver it (see handshake) and go to IDLE.
  - rx_s == 0 -> framing_error pulses for one cycle, byte discarded, enter BREAK.
- State BREAK:
  - Stay until rx_s == 1, then go to IDLE.
  - A held-low line (break condition) produces exactly one framing_error and no spurious frames.
- Handshake:
  - A transfer occurs on any clock edge where data_valid && data_ready.
  - On byte completion, data and data_valid update on the clock edge at the stop sample point, i.e. they are visible the cycle after the stop-bit tick.
  - data is stable while data_valid is high.
  - data_valid deasserts on the edge after a transfer unless a new byte loads on that same edge.
  - Byte completes while data_valid = 1 and data_ready = 0:
    - overrun pulses for one cycle.
    - The new byte is dropped; the old data and data_valid are retained.
  - Byte completes on the same cycle as a transfer: the new byte loads, data_valid stays 1, no overrun.
- tick and state activity are independent of the handshake; the receiver never stalls.
- Reset asserted mid-frame aborts the frame with no output pulse. After release, reception restarts from IDLE.

Test Plan (tick driven every 4 clocks, SAMPLE_RATE = 16, DATA_BITS = 8, 64 clocks/bit):
- Frame 0xA5 sent (start 0, bits 1,0,1,0,0,1,0,1, stop 1), data_ready = 0 -> data = 0xA5, data_valid = 1 from the cycle after the stop sample until data_ready is raised; no error pulses.
- rx low for 5 ticks (20 clocks), then high -> no state change past START, data_valid stays 0, no pulses.
- Frame 0x3C with stop bit driven 0, rx held low a further 10 bits, then high -> one framing_error pulse, data_valid = 0; a following 0x55 frame is received correctly.
- Back-to-back 0x12, 0x34 with data_ready = 0 -> data = 0x12 retained, overrun pulses once at the second stop sample; then data_ready = 1 -> data_valid drops next cycle.
- Same two frames with data_ready tied 1 -> two single-cycle data_valid pulses carrying 0x12 then 0x34; overrun never asserts.
- reset_n pulsed low during bit 4 of frame 0xFF -> outputs clear asynchronously; the next frame 0x81 is received as 0x81.

Source files
------------

// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling off an
// oversample tick, valid/ready output buffer with framing/overrun flags.
//
// Ports:
//   clock         system clock
//   reset_n       asynchronous active-low reset
//   tick          one-cycle oversample strobe (BAUD*SAMPLE_RATE)
//   rx            asynchronous serial line, idle high
//   data          received byte, LSB = first bit on the line
//   data_valid    data holds an unconsumed byte
//   data_ready    consumer accepts data when high with data_valid
//   framing_error one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: completed byte dropped, buffer full
module uart_rx_oversampler #(
   parameter int SAMPLE_RATE = 16,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 framing_error,
   output logic                 overrun
);

   localparam int TW = $clog2(SAMPLE_RATE);
   localparam int BW = $clog2(DATA_BITS + 1);

   // Sample fires on the tick that would take the count to the target.
   localparam logic [TW-1:0] TC_HALF = TW'(SAMPLE_RATE / 2 - 1);
   localparam logic [TW-1:0] TC_FULL = TW'(SAMPLE_RATE - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [2:0]           r_state;
   logic [TW-1:0]        r_tcnt;
   logic [BW-1:0]        r_bcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_fe;
   logic                 r_ov;

   logic [TW-1:0]        w_target;
   logic                 w_sample;
   logic                 w_xfer;

   assign data          = r_data;
   assign data_valid    = r_valid;
   assign framing_error = r_fe;
   assign overrun       = r_ov;

   always_comb begin
      w_target = TC_FULL;
      if (r_state == S_START)
         w_target = TC_HALF;
      w_sample = tick && (r_tcnt == w_target);
      w_xfer   = r_valid && data_ready;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_fe    <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         r_fe <= 1'b0;
         r_ov <= 1'b0;
         // A load later in this block overrides the drop.
         if (w_xfer)
            r_valid <= 1'b0;

         if (tick && r_state != S_IDLE && r_state != S_BREAK) begin
            if (w_sample)
               r_tcnt <= '0;
            else
               r_tcnt <= r_tcnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_tcnt  <= '0;
               end
            end
            S_START: begin
               if (w_sample) begin
                  if (!r_rx_s) begin
                     r_state <= S_DATA;
                     r_bcnt  <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (w_sample) begin
                  r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_bcnt == BC_LAST)
                     r_state <= S_STOP;
                  else
                     r_bcnt <= r_bcnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_sample) begin
                  if (r_rx_s) begin
                     r_state <= S_IDLE;
                     if (!r_valid || data_ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_ov <= 1'b1;
                     end
                  end else begin
                     r_fe    <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (r_rx_s)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: tick every 4 clocks,
// 64 clocks per bit, immediate assertions at each check point.
module tb_uart_rx_oversampler;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       rx;
   logic       data_ready;
   logic [7:0] data;
   logic       data_valid;
   logic       fe;
   logic       ov;

   int n_pass  = 0;
   int n_total = 0;
   int n_fe    = 0;
   int n_ov    = 0;
   int n_vcyc  = 0;
   int tph     = 0;
   int base_ov;
   int base_v;
   bit cap_en  = 0;
   logic [7:0] cap[$];

   uart_rx_oversampler #(.SAMPLE_RATE(16), .DATA_BITS(8)) dut (
      .clock         (clk),
      .reset_n       (rst_n),
      .tick          (tick),
      .rx            (rx),
      .data          (data),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .framing_error (fe),
      .overrun       (ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick = (tph == 3);
         tph  = (tph + 1) % 4;
      end
   end

   always @(negedge clk) begin
      if (fe) n_fe++;
      if (ov) n_ov++;
      if (cap_en && data_valid) begin
         n_vcyc++;
         cap.push_back(data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (64) @(posedge clk);
      #1;
   endtask

   task automatic send_data(input logic [7:0] b);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++)
         bit_time(b[i]);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      rx         = 1'b1;
      data_ready = 1'b0;
      #2;
      chk("rst_data",  32'(data), 32'h00);
      chk("rst_valid", 32'(data_valid), 32'h0);
      chk("rst_fe",    32'(fe), 32'h0);
      chk("rst_ov",    32'(ov), 32'h0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(100);

      // 0xA5, consumer not ready
      send_data(8'hA5);
      chk("a5_pre_stop_valid", 32'(data_valid), 32'h0);
      bit_time(1'b1);
      chk("a5_data",  32'(data), 32'hA5);
      chk("a5_valid", 32'(data_valid), 32'h1);
      idle(200);
      chk("a5_hold_data",  32'(data), 32'hA5);
      chk("a5_hold_valid", 32'(data_valid), 32'h1);
      chk("a5_no_fe", 32'(n_fe), 32'd0);
      chk("a5_no_ov", 32'(n_ov), 32'd0);
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("a5_consumed", 32'(data_valid), 32'h0);
      data_ready = 1'b0;
      idle(64);

      // 20-clock glitch
      rx = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      idle(200);
      chk("glitch_valid", 32'(data_valid), 32'h0);
      chk("glitch_fe", 32'(n_fe), 32'd0);
      chk("glitch_ov", 32'(n_ov), 32'd0);

      // 0x3C with bad stop, held low 10 more bits
      send_data(8'h3C);
      bit_time(1'b0);
      for (int i = 0; i < 10; i++)
         bit_time(1'b0);
      idle(64);
      chk("brk_fe_once", 32'(n_fe), 32'd1);
      chk("brk_valid",   32'(data_valid), 32'h0);
      send_data(8'h55);
      bit_time(1'b1);
      chk("f55_data",  32'(data), 32'h55);
      chk("f55_valid", 32'(data_valid), 32'h1);
      chk("f55_fe",    32'(n_fe), 32'd1);
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("f55_consumed", 32'(data_valid), 32'h0);
      data_ready = 1'b0;
      idle(64);

      // back-to-back, not ready -> overrun
      send_data(8'h12);
      bit_time(1'b1);
      chk("ov_first_data", 32'(data), 32'h12);
      chk("ov_none_yet",   32'(n_ov), 32'd0);
      send_data(8'h34);
      bit_time(1'b1);
      chk("ov_once",     32'(n_ov), 32'd1);
      chk("ov_retained", 32'(data), 32'h12);
      chk("ov_valid",    32'(data_valid), 32'h1);
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ov_consumed", 32'(data_valid), 32'h0);
      idle(64);

      // back-to-back, ready tied high
      base_ov = n_ov;
      base_v  = n_vcyc;
      cap.delete();
      cap_en = 1'b1;
      send_data(8'h12);
      bit_time(1'b1);
      send_data(8'h34);
      bit_time(1'b1);
      idle(64);
      cap_en = 1'b0;
      chk("rdy_vcycles", 32'(n_vcyc - base_v), 32'd2);
      chk("rdy_ncap", 32'(cap.size()), 32'd2);
      if (cap.size() == 2) begin
         chk("rdy_cap0", 32'(cap[0]), 32'h12);
         chk("rdy_cap1", 32'(cap[1]), 32'h34);
      end
      chk("rdy_no_ov", 32'(n_ov - base_ov), 32'd0);
      data_ready = 1'b0;

      // reset mid bit 4 of 0xFF
      bit_time(1'b0);
      for (int i = 0; i < 4; i++)
         bit_time(1'b1);
      rx = 1'b1;
      repeat (32) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mrst_data",  32'(data), 32'h00);
      chk("mrst_valid", 32'(data_valid), 32'h0);
      chk("mrst_fe",    32'(fe), 32'h0);
      chk("mrst_ov",    32'(ov), 32'h0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(300);
      chk("mrst_idle_valid", 32'(data_valid), 32'h0);
      send_data(8'h81);
      bit_time(1'b1);
      idle(16);
      chk("f81_data",  32'(data), 32'h81);
      chk("f81_valid", 32'(data_valid), 32'h1);
      chk("f81_fe", 32'(n_fe), 32'd1);
      chk("f81_ov", 32'(n_ov), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
